// File: rtl/serial_sorter_pkg.sv
// serial_sorter_pkg: shared state encoding and sizing helpers for serial_sorter.
package serial_sorter_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Number of bits needed to hold an element count of 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_sorter_cell.sv
// serial_sorter_cell: one storage slot of the insertion array.
// Holds one element, compares it against the incoming element and picks
// between hold, take the new element, shift up from the lower neighbour,
// or shift down from the upper neighbour.
// Build option: SERIAL_SORTER_DESCEND_EN selects descending order.
module serial_sorter_cell
    import serial_sorter_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          insert,
    input  logic          shift,
    input  logic          occupied,
    input  logic          in_range,
    input  logic          lower_keep,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] lower,
    input  logic [DW-1:0] upper,
    output logic [DW-1:0] value,
    output logic          keep
);

    logic cmp;

`ifdef SERIAL_SORTER_DESCEND_EN
    assign cmp = (value >= x);
`else
    assign cmp = (value <= x);
`endif

    // An occupied slot that sorts ahead of (or equal to) x stays put, which keeps ties stable.
    assign keep = occupied & cmp;

    // Slot update: insertion point takes x, slots above it shift up, drain shifts down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (insert && in_range && !keep) begin
            value <= lower_keep ? x : lower;
        end else if (shift) begin
            value <= upper;
        end
    end

endmodule

// File: rtl/serial_sorter.sv
// serial_sorter: streaming insertion sorter. Fills up to N elements one per
// cycle, keeping the array sorted, then drains them one per cycle.
// Build option: SERIAL_SORTER_DESCEND_EN selects descending order (in the cells).
module serial_sorter
    import serial_sorter_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int CW = count_width(N);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic [DW-1:0] cells [N];
    logic [N-1:0]  keeps;
    logic          insert;
    logic          shift;
    logic          frame_end;

    assign insert    = in_valid & in_ready;
    assign shift     = out_valid & out_ready;
    assign frame_end = insert & (in_last | (count == CW'(N - 1)));

    // Next-state and element count: grow on accept, shrink on drain handshake.
    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            FILL: begin
                if (insert) begin
                    next_count = count + CW'(1);
                end
                if (frame_end) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (shift) begin
                    next_count = count - CW'(1);
                    if (count == CW'(1)) begin
                        next_state = FILL;
                    end
                end
            end
            default: next_state = FILL;
        endcase
    end

    // State, count and registered handshake flags; in_ready stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            count     <= next_count;
            in_ready  <= (next_state == FILL);
            out_valid <= (next_state == DRAIN);
        end
    end

    assign out_data = out_valid ? cells[0] : '0;
    assign out_last = out_valid & (count == CW'(1));

    for (genvar i = 0; i < N; i++) begin : g_cell
        logic [DW-1:0] lower;
        logic [DW-1:0] upper;
        logic          lower_keep;

        if (i == 0) begin : g_first
            assign lower      = '0;
            assign lower_keep = 1'b1;
        end else begin : g_rest
            assign lower      = cells[i-1];
            assign lower_keep = keeps[i-1];
        end

        if (i == N - 1) begin : g_top
            assign upper = '0;
        end else begin : g_mid
            assign upper = cells[i+1];
        end

        serial_sorter_cell #(.DW(DW)) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .insert     (insert),
            .shift      (shift),
            .occupied   (count > CW'(i)),
            .in_range   (count >= CW'(i)),
            .lower_keep (lower_keep),
            .x          (in_data),
            .lower      (lower),
            .upper      (upper),
            .value      (cells[i]),
            .keep       (keeps[i])
        );
    end

endmodule

// File: tb/tb_serial_sorter.sv
// tb_serial_sorter: table-driven frames with a scoreboard queue of expected
// sorted outputs, plus hand-written reset and mid-drain reset sequences.
module tb_serial_sorter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        int              len;
        int              mode;
        logic [0:3][7:0] din;
        logic [0:3][7:0] exp_asc;
        logic [0:3][7:0] exp_desc;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_sorter #(.N(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Sends one frame (mode 1 adds out_ready backpressure and in_valid junk during drain)
    // and drains it, stopping early after max_pops handshakes when max_pops >= 0.
    task automatic apply_stimulus(input vec_t v, input int max_pops);
        logic [0:3][7:0] exp;
        int pops;
        int cyc;
        exp_t e;
`ifdef SERIAL_SORTER_DESCEND_EN
        exp = v.exp_desc;
`else
        exp = v.exp_asc;
`endif
        for (int k = 0; k < v.len; k++) begin
            e.data = exp[k];
            e.last = (k == v.len - 1);
            sb.push_back(e);
        end
        for (int j = 0; j < v.len; j++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = v.din[j];
            in_last  = (j == v.len - 1);
            check_output("in_ready_fill", in_ready, 1);
        end
        @(negedge clk);
        in_valid = (v.mode == 1);
        in_data  = 8'hAA;
        in_last  = 1'b1;
        check_output("latency_out_valid", out_valid, 1);
        pops = 0;
        cyc  = 0;
        while (sb.size() > 0 && pops != max_pops && cyc < 40) begin
            if (v.mode == 1) begin
                out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            end else begin
                out_ready = 1'b1;
            end
            check_output("drain_valid", out_valid, 1);
            check_output("drain_data", out_data, sb[0].data);
            check_output("drain_last", out_last, sb[0].last);
            check_output("drain_in_ready", in_ready, 0);
            if (out_ready) begin
                void'(sb.pop_front());
                pops++;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        checks++;
        if (cyc < 40) begin
            passed++;
        end else begin
            $display("[TB] FAIL drain_timeout: got %0d cycles required under 40", cyc);
        end
        if (sb.size() == 0) begin
            check_output("resume_in_ready", in_ready, 1);
            check_output("resume_out_valid", out_valid, 0);
        end
    endtask

    initial begin
        vecs[0] = '{4, 0, {8'd7, 8'd3, 8'd9, 8'd1}, {8'd1, 8'd3, 8'd7, 8'd9}, {8'd9, 8'd7, 8'd3, 8'd1}};
        vecs[1] = '{2, 0, {8'd5, 8'd2, 8'd0, 8'd0}, {8'd2, 8'd5, 8'd0, 8'd0}, {8'd5, 8'd2, 8'd0, 8'd0}};
        vecs[2] = '{4, 0, {8'd255, 8'd0, 8'd255, 8'd0}, {8'd0, 8'd0, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd0, 8'd0}};
        vecs[3] = '{4, 1, {8'd200, 8'd17, 8'd99, 8'd17}, {8'd17, 8'd17, 8'd99, 8'd200}, {8'd200, 8'd99, 8'd17, 8'd17}};
        vecs[4] = '{1, 0, {8'd42, 8'd0, 8'd0, 8'd0}, {8'd42, 8'd0, 8'd0, 8'd0}, {8'd42, 8'd0, 8'd0, 8'd0}};
        vecs[5] = '{4, 0, {8'd4, 8'd8, 8'd6, 8'd2}, {8'd2, 8'd4, 8'd6, 8'd8}, {8'd8, 8'd6, 8'd4, 8'd2}};

        #12;
        check_output("reset_in_ready", in_ready, 0);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_out_data", out_data, 0);
        check_output("reset_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("release_in_ready_low", in_ready, 0);
        @(negedge clk);
        check_output("release_in_ready_high", in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i], -1);
        end

        apply_stimulus(vecs[0], 2);
        rst_n = 1'b0;
        #1;
        check_output("midreset_out_valid", out_valid, 0);
        check_output("midreset_out_data", out_data, 0);
        check_output("midreset_out_last", out_last, 0);
        check_output("midreset_in_ready", in_ready, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("midreset_resume", in_ready, 1);
        apply_stimulus(vecs[5], -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

endmodule
